bin_to_bcd_seq: RTL
===================

# bin_to_bcd_seq

Sequential double-dabble binary-to-BCD converter. Sits directly downstream of the Fibonacci compute FSM: it takes the binary result and produces packed BCD digits for the seven-segment display multiplexer. Costs one shift/adjust cycle per input bit, using one adder per digit instead of a combinational cascade.

## Interface
- BIN_W, default 14: width of the binary input.
- DIGITS, default 4: number of BCD output digits.
- clk_i  input  1  system clock; all logic on rising edge.
- reset_ni  input  1  reset; synchronous, active-low.
- start_i  input  1  conversion request, sampled only while ready_o=1.
- bin_i  input  BIN_W  binary value, captured on the accepted start cycle.
- ready_o  output  1  high in IDLE only.
- done_tick_o  output  1  one-cycle pulse when bcd_o and overflow_o are updated.
- bcd_o  output  4*DIGITS  packed BCD; digit 0 is in bits [3:0].
- overflow_o  output  1  high when the last converted value was ≥ 10^DIGITS.

## Operation
- FSM states (typedef state_bcd_d): IDLE, OP_SHIFT, DONE.
- IDLE, start_i=1:
  - Load shift register ← bin_i.
  - Clear BCD accumulator and the sticky overflow bit.
  - Iteration counter ← BIN_W-1.
  - Next state OP_SHIFT.
- IDLE, start_i=0: stay in IDLE.
- OP_SHIFT, each cycle:
  - Every accumulator digit ≥5 gets +3.
  - Shift {accumulator, shift register} left by 1.
  - If the adjusted top digit is ≥8 (a bit is shifted out), set sticky overflow.
  - Counter decrements.
  - When counter==0, next state is DONE and the final accumulator/overflow are written to the bcd_o/overflow_o registers on that same edge.
- DONE: done_tick_o=1 for exactly one cycle, then IDLE unconditionally.
- start_i outside IDLE is ignored and is not queued.
- bin_i changes after the accepted start cycle have no effect.
- bcd_o and overflow_o hold their values until the next done_tick_o.
- Width rules:
  - Accumulator is 4*DIGITS bits.
  - Counter width is $clog2(BIN_W).
  - BIN_W ≥ 1 and DIGITS ≥ 1.

## Timing
- Reset (reset_ni=0 at an edge), in any state including mid-conversion:
  - State → IDLE.
  - bcd_o=0, overflow_o=0, done_tick_o=0.
  - ready_o=1 from the next cycle.
  - Any conversion in progress is abandoned with no done_tick_o.
- start accepted at edge N:
  - OP_SHIFT occupies cycles N+1 … N+BIN_W.
  - DONE at cycle N+BIN_W+1: done_tick_o=1, and bcd_o/overflow_o are already valid.
  - IDLE (ready_o=1) at cycle N+BIN_W+2.
- Default BIN_W=14: 16 cycles from accept to ready again.
- ready_o and done_tick_o are decoded from the state register; they are glitch-free and have no combinational path from inputs.
- Back-to-back: start_i held high converts again immediately on the first IDLE cycle.

## Configuration
- Macro BIN_TO_BCD_SATURATE_EN.
- Defined: on overflow, bcd_o is loaded with all digits = 9 (9999 for DIGITS=4), and overflow_o=1.
- Undefined: on overflow, bcd_o holds the low DIGITS decimal digits (value mod 10^DIGITS), and overflow_o=1.
- Overflow detection and overflow_o are present in both builds.

## Structure
- Shared package bcd_pkg contains:
  - state_bcd_d typedef.
  - BCD_DIGIT_W=4.
  - BCD_ADJ_THRESH=5 and BCD_ADJ_ADD=3.
- One sub-module, bcd_add3: combinational per-digit "if ≥5 then +3", instantiated DIGITS times in a generate loop.
- No other sub-modules.

## Test plan
- Reset, then bin_i=6765, start pulse at edge N → done_tick_o at N+15, bcd_o=16'h6765, overflow_o=0, ready_o=1 at N+16.
- bin_i=0 → bcd_o=16'h0000, overflow_o=0; bin_i=9999 → bcd_o=16'h9999, overflow_o=0.
- bin_i=10946 → overflow_o=1; bcd_o=16'h9999 with BIN_TO_BCD_SATURATE_EN, 16'h0946 without.
- start_i pulsed again at N+5 with bin_i=1234 while converting 6765 → result still 16'h6765, and only one done_tick_o.
- reset_ni=0 for one cycle at N+7 mid-conversion → next cycle ready_o=1, bcd_o=0, and no done_tick_o; a new start with 21 → 16'h0021.
- start_i held high with bin_i=55 → done_tick_o every 16 cycles, and bcd_o=16'h0055 each time.

Source files
------------

// File: rtl/bcd_pkg.sv
// Shared types and constants for the sequential double-dabble BCD converter.
package bcd_pkg;

   typedef enum logic [1:0] {
      IDLE,
      OP_SHIFT,
      DONE
   } state_bcd_d;

   localparam int         BCD_DIGIT_W    = 4;
   localparam logic [3:0] BCD_ADJ_THRESH = 4'd5;
   localparam logic [3:0] BCD_ADJ_ADD    = 4'd3;

endpackage

// File: rtl/bcd_add3.sv
// Per-digit double-dabble adjust: a digit of 5 or more gets +3 so the following
// left shift carries correctly into the next decimal digit.
module bcd_add3
   import bcd_pkg::*;
(
   input  logic [BCD_DIGIT_W-1:0] i_digit,
   output logic [BCD_DIGIT_W-1:0] o_digit
);

   assign o_digit = (i_digit >= BCD_ADJ_THRESH) ? (i_digit + BCD_ADJ_ADD) : i_digit;

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter, one shift/adjust cycle per input bit.
// Define BIN_TO_BCD_SATURATE_EN to clamp overflowing results to all nines.
module bin_to_bcd_seq
   import bcd_pkg::*;
#(
   parameter int BIN_W  = 14,
   parameter int DIGITS = 4
)
(
   input  logic                        clk_i,
   input  logic                        reset_ni,
   input  logic                        start_i,
   input  logic [BIN_W-1:0]            bin_i,
   output logic                        ready_o,
   output logic                        done_tick_o,
   output logic [BCD_DIGIT_W*DIGITS-1:0] bcd_o,
   output logic                        overflow_o
);

   localparam int ACC_W = BCD_DIGIT_W * DIGITS;
   localparam int CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;

   state_bcd_d       r_state;
   logic [BIN_W-1:0] r_shift;
   logic [ACC_W-1:0] r_acc;
   logic [ACC_W-1:0] r_bcd;
   logic [CNT_W-1:0] r_cnt;
   logic             r_ovf;
   logic             r_ovf_out;

   logic [ACC_W-1:0] w_adj;
   logic [ACC_W-1:0] w_acc_nxt;
   logic             w_ovf_nxt;

   function automatic logic [ACC_W-1:0] sat_nines();
      logic [ACC_W-1:0] v;
      for (int d = 0; d < DIGITS; d++) v[d*BCD_DIGIT_W +: BCD_DIGIT_W] = 4'd9;
      return v;
   endfunction

   for (genvar g = 0; g < DIGITS; g++) begin : g_digit
      bcd_add3 u_add3 (
         .i_digit (r_acc[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
         .o_digit (w_adj[g*BCD_DIGIT_W +: BCD_DIGIT_W])
      );
   end

   // A set MSB in the adjusted top digit is lost by the shift: value >= 10^DIGITS.
   assign w_acc_nxt = {w_adj[ACC_W-2:0], r_shift[BIN_W-1]};
   assign w_ovf_nxt = r_ovf | w_adj[ACC_W-1];

   always_ff @(posedge clk_i) begin
      if (!reset_ni) begin
         r_state   <= IDLE;
         r_bcd     <= '0;
         r_ovf_out <= 1'b0;
         r_ovf     <= 1'b0;
         r_cnt     <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (start_i) begin
                  r_shift <= bin_i;
                  r_acc   <= '0;
                  r_ovf   <= 1'b0;
                  r_cnt   <= CNT_W'(BIN_W - 1);
                  r_state <= OP_SHIFT;
               end
            end
            OP_SHIFT: begin
               r_acc   <= w_acc_nxt;
               r_shift <= r_shift << 1;
               r_ovf   <= w_ovf_nxt;
               r_cnt   <= r_cnt - 1'b1;
               if (r_cnt == '0) begin
                  r_state   <= DONE;
                  r_ovf_out <= w_ovf_nxt;
`ifdef BIN_TO_BCD_SATURATE_EN
                  r_bcd     <= w_ovf_nxt ? sat_nines() : w_acc_nxt;
`else
                  r_bcd     <= w_acc_nxt;
`endif
               end
            end
            DONE:    r_state <= IDLE;
            default: r_state <= IDLE;
         endcase
      end
   end

   assign ready_o     = (r_state == IDLE);
   assign done_tick_o = (r_state == DONE);
   assign bcd_o       = r_bcd;
   assign overflow_o  = r_ovf_out;

endmodule
